// File: rtl/multi_ones_counter_if.sv
// Handshake/control bundle for multi_ones_counter.
// `MULTI_ONES_COUNTER_OVERRUN_EN adds the sticky overrun flag.
interface multi_ones_counter_if #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned MAX_SAMPLES = 1650
);
  localparam int unsigned CW = $clog2(MAX_SAMPLES + 1);

  logic                   sample_en;
  logic [NUM_CH-1:0]      pulse;
  logic [CW-1:0]          win_len;
  logic                   continuous;
  logic                   start;
  logic                   stop;
  logic                   busy;
  logic [NUM_CH*CW-1:0]   ones;
  logic                   out_valid;
  logic                   out_ready;
`ifdef MULTI_ONES_COUNTER_OVERRUN_EN
  logic                   overrun;
`endif

  modport slave (
    input  sample_en, pulse, win_len, continuous, start, stop, out_ready,
    output busy, ones, out_valid
`ifdef MULTI_ONES_COUNTER_OVERRUN_EN
    , output overrun
`endif
  );

  modport master (
    output sample_en, pulse, win_len, continuous, start, stop, out_ready,
    input  busy, ones, out_valid
`ifdef MULTI_ONES_COUNTER_OVERRUN_EN
    , input overrun
`endif
  );
endinterface

// File: rtl/multi_ones_counter.sv
// Counts '1' samples on NUM_CH pulse streams over a programmable window with valid/ready output.
// `MULTI_ONES_COUNTER_OVERRUN_EN adds a sticky overrun flag for overwritten unconsumed results.
module multi_ones_counter #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned MAX_SAMPLES = 1650
) (
  input logic                  clk,
  input logic                  rst_n,
  multi_ones_counter_if.slave  bus
);
  localparam int unsigned CW = $clog2(MAX_SAMPLES + 1);
  localparam logic [CW-1:0] MaxLen = CW'(MAX_SAMPLES);

  typedef enum logic [0:0] {StIdle, StCount} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        len_q, len_d;
  logic                 cont_q, cont_d;
  logic [CW-1:0]        acc_q [NUM_CH];
  logic [CW-1:0]        acc_d [NUM_CH];
  logic [CW-1:0]        scnt_q, scnt_d;
  logic [NUM_CH*CW-1:0] ones_q, ones_d;
  logic                 valid_q, valid_d;
  logic                 start_ok;
  logic                 win_end;

  assign start_ok = (state_q == StIdle) && bus.start && (bus.win_len != '0);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cont_d  = cont_q;
    acc_d   = acc_q;
    scnt_d  = scnt_q;
    ones_d  = ones_q;
    valid_d = valid_q;
    win_end = 1'b0;

    if (valid_q && bus.out_ready) valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          len_d   = (bus.win_len > MaxLen) ? MaxLen : bus.win_len;
          cont_d  = bus.continuous;
          scnt_d  = '0;
          for (int i = 0; i < NUM_CH; i++) acc_d[i] = '0;
          state_d = StCount;
        end
      end
      StCount: begin
        if (bus.stop) begin
          // Abort wins over a coincident window end.
          scnt_d  = '0;
          for (int i = 0; i < NUM_CH; i++) acc_d[i] = '0;
          state_d = StIdle;
        end else if (bus.sample_en) begin
          if (scnt_q == len_q - CW'(1)) begin
            win_end = 1'b1;
            valid_d = 1'b1;
            scnt_d  = '0;
            for (int i = 0; i < NUM_CH; i++) begin
              ones_d[i*CW +: CW] = acc_q[i] + CW'(bus.pulse[i]);
              acc_d[i]           = '0;
            end
            if (!cont_q) state_d = StIdle;
          end else begin
            scnt_d = scnt_q + CW'(1);
            for (int i = 0; i < NUM_CH; i++) acc_d[i] = acc_q[i] + CW'(bus.pulse[i]);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      len_q   <= '0;
      cont_q  <= 1'b0;
      scnt_q  <= '0;
      ones_q  <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cont_q  <= cont_d;
      scnt_q  <= scnt_d;
      ones_q  <= ones_d;
      valid_q <= valid_d;
      for (int i = 0; i < NUM_CH; i++) acc_q[i] <= acc_d[i];
    end
  end

`ifdef MULTI_ONES_COUNTER_OVERRUN_EN
  logic ovr_q, ovr_d;

  always_comb begin
    ovr_d = ovr_q;
    if (start_ok) ovr_d = 1'b0;
    if (win_end && valid_q && !bus.out_ready) ovr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovr_q <= 1'b0;
    else        ovr_q <= ovr_d;
  end

  assign bus.overrun = ovr_q;
`endif

  assign bus.busy      = (state_q == StCount);
  assign bus.ones      = ones_q;
  assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_multi_ones_counter.sv
// Directed and randomized checks of multi_ones_counter against a sample-queue reference model.
module tb_multi_ones_counter;
  localparam int unsigned NUM_CH      = 4;
  localparam int unsigned MAX_SAMPLES = 1650;
  localparam int unsigned CW          = 11;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  multi_ones_counter_if #(.NUM_CH(NUM_CH), .MAX_SAMPLES(MAX_SAMPLES)) bus ();

  multi_ones_counter #(.NUM_CH(NUM_CH), .MAX_SAMPLES(MAX_SAMPLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pack4(input int c0, input int c1, input int c2, input int c3);
    logic [NUM_CH*CW-1:0] v;
    v = '0;
    v[0*CW +: CW] = CW'(c0);
    v[1*CW +: CW] = CW'(c1);
    v[2*CW +: CW] = CW'(c2);
    v[3*CW +: CW] = CW'(c3);
    return 64'(v);
  endfunction

  task automatic do_start(input int len, input logic cont);
    bus.win_len    = CW'(len);
    bus.continuous = cont;
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
  endtask

  // Reference model: samples of the open window are queued, results summed per channel.
  logic [NUM_CH-1:0] mq[$];
  bit                m_active;
  bit                m_cont;
  bit                m_valid;
  bit                m_ovr;
  int                m_len;
  int                m_ones[NUM_CH];

  task automatic model_step();
    bit end_evt;
    end_evt = 0;
    if (!m_active) begin
      if (bus.start && bus.win_len != 0) begin
        m_active = 1;
        m_len    = (int'(bus.win_len) > MAX_SAMPLES) ? MAX_SAMPLES : int'(bus.win_len);
        m_cont   = bus.continuous;
        m_ovr    = 0;
        mq.delete();
      end
    end else if (bus.stop) begin
      m_active = 0;
      mq.delete();
    end else if (bus.sample_en) begin
      mq.push_back(bus.pulse);
      if (mq.size() == m_len) begin
        end_evt = 1;
        for (int c = 0; c < NUM_CH; c++) begin
          m_ones[c] = 0;
          foreach (mq[k]) m_ones[c] += int'(mq[k][c]);
        end
        mq.delete();
        if (!m_cont) m_active = 0;
      end
    end
    if (end_evt) begin
      if (m_valid && !bus.out_ready) m_ovr = 1;
      m_valid = 1;
    end else if (bus.out_ready) begin
      m_valid = 0;
    end
  endtask

  initial begin
    int n;
    int samp;
    rst_n          = 1'b0;
    bus.sample_en  = 1'b0;
    bus.pulse      = '0;
    bus.win_len    = '0;
    bus.continuous = 1'b0;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.out_ready  = 1'b0;
    tick();
    tick();
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_ones", 64'(bus.ones), 64'd0);
`ifdef MULTI_ONES_COUNTER_OVERRUN_EN
    check("rst_ovr", 64'(bus.overrun), 64'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Single window of 10, constant pattern.
    bus.sample_en = 1'b1;
    bus.pulse     = 4'b0101;
    bus.out_ready = 1'b1;
    do_start(10, 1'b0);
    check("t1_busy", 64'(bus.busy), 64'd1);
    n = 0;
    while (!bus.out_valid && n < 50) begin tick(); n++; end
    check("t1_latency", 64'(n), 64'd10);
    check("t1_ones", 64'(bus.ones), pack4(10, 0, 10, 0));
    check("t1_busy_drop", 64'(bus.busy), 64'd0);
    tick();
    check("t1_valid_1cyc", 64'(bus.out_valid), 64'd0);

    // Toggling sample_en, result 16 cycles after start.
    bus.pulse = 4'b0001;
    do_start(8, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      n++;
      bus.sample_en = (n % 2 == 0);
      tick();
    end
    check("t2_latency", 64'(n), 64'd16);
    check("t2_ones", 64'(bus.ones), pack4(8, 0, 0, 0));
    bus.sample_en = 1'b1;

    // Continuous windows of 5 with alternating pulse[0].
    bus.pulse = 4'b0000;
    do_start(5, 1'b1);
    for (int k = 1; k <= 15; k++) begin
      bus.pulse = ((k - 1) % 2 == 0) ? 4'b0001 : 4'b0000;
      tick();
      check($sformatf("t3_valid_%0d", k), 64'(bus.out_valid), 64'(k % 5 == 0));
      if (k % 5 == 0)
        check($sformatf("t3_ones_%0d", k), 64'(bus.ones),
              pack4(((k / 5) % 2 == 1) ? 3 : 2, 0, 0, 0));
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("t3_stop_busy", 64'(bus.busy), 64'd0);

    // Two window ends with out_ready low: latest result wins.
    bus.out_ready = 1'b0;
    bus.pulse     = 4'b1111;
    do_start(5, 1'b1);
    repeat (5) tick();
    check("t4_valid1", 64'(bus.out_valid), 64'd1);
    check("t4_ones1", 64'(bus.ones), pack4(5, 5, 5, 5));
`ifdef MULTI_ONES_COUNTER_OVERRUN_EN
    check("t4_ovr0", 64'(bus.overrun), 64'd0);
`endif
    bus.pulse = 4'b0011;
    repeat (5) tick();
    check("t4_valid2", 64'(bus.out_valid), 64'd1);
    check("t4_ones2", 64'(bus.ones), pack4(5, 5, 0, 0));
`ifdef MULTI_ONES_COUNTER_OVERRUN_EN
    check("t4_ovr1", 64'(bus.overrun), 64'd1);
`endif
    bus.out_ready = 1'b1;
    tick();
    check("t4_consumed", 64'(bus.out_valid), 64'd0);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;

    // Stop on the window-end cycle discards the result.
    do_start(3, 1'b0);
    tick();
    tick();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("t5_valid", 64'(bus.out_valid), 64'd0);
    check("t5_busy", 64'(bus.busy), 64'd0);
    check("t5_ones_kept", 64'(bus.ones), pack4(5, 5, 0, 0));
    do_start(0, 1'b0);
    check("t5_zero_len", 64'(bus.busy), 64'd0);
`ifdef MULTI_ONES_COUNTER_OVERRUN_EN
    check("t5_ovr_sticky", 64'(bus.overrun), 64'd1);
`endif

    // Async reset mid-window, then clamped long window.
    do_start(20, 1'b0);
`ifdef MULTI_ONES_COUNTER_OVERRUN_EN
    check("t6_ovr_clr", 64'(bus.overrun), 64'd0);
`endif
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", 64'(bus.busy), 64'd0);
    check("t6_rst_valid", 64'(bus.out_valid), 64'd0);
    check("t6_rst_ones", 64'(bus.ones), 64'd0);
    tick();
    rst_n     = 1'b1;
    bus.pulse = 4'b1111;
    do_start(2000, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 3000) begin tick(); n++; end
    check("t6_clamp_len", 64'(n), 64'd1650);
    check("t6_clamp_ones", 64'(bus.ones), pack4(1650, 1650, 1650, 1650));
    tick();

    // Randomized run against the reference model.
    m_active = 0;
    m_cont   = 0;
    m_valid  = 0;
    m_ovr    = 0;
    m_len    = 0;
    for (int c = 0; c < NUM_CH; c++) m_ones[c] = 1650;
    for (int k = 0; k < 400; k++) begin
      samp           = int'($urandom_range(0, 99));
      bus.start      = ($urandom_range(0, 7) == 0);
      bus.stop       = ($urandom_range(0, 39) == 0);
      bus.win_len    = CW'($urandom_range(0, 12));
      bus.continuous = $urandom_range(0, 1) != 0;
      bus.sample_en  = (samp < 75);
      bus.pulse      = NUM_CH'($urandom);
      bus.out_ready  = $urandom_range(0, 1) != 0;
      model_step();
      tick();
      check($sformatf("rnd_busy_%0d", k), 64'(bus.busy), 64'(m_active));
      check($sformatf("rnd_valid_%0d", k), 64'(bus.out_valid), 64'(m_valid));
      check($sformatf("rnd_ones_%0d", k), 64'(bus.ones),
            pack4(m_ones[0], m_ones[1], m_ones[2], m_ones[3]));
`ifdef MULTI_ONES_COUNTER_OVERRUN_EN
      check($sformatf("rnd_ovr_%0d", k), 64'(bus.overrun), 64'(m_ovr));
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
